// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and its SRAM command mux.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int SRAM_ADDR_W    = 16;
    localparam int SRAM_DATA_W    = 128;

    typedef enum logic [1:0] {
        ARK   = 2'd0,
        SUB   = 2'd1,
        SHIFT = 2'd2,
        MIX   = 2'd3
    } step_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } sched_state_e;

    function automatic logic [3:0] step_onehot(input step_e s);
        step_onehot = 4'b0001 << s;
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Selects one step's SRAM command bundle by grant index; drives all zeros when nothing is granted.
module sram_port_mux
    import aes_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic [1:0]          grant,
    input  logic                grant_valid,
    input  logic [3:0]          in_read,
    input  logic [3:0]          in_write,
    input  logic [3:0]          in_dump,
    input  logic [3:0]          in_init,
    input  logic [4*ADDR_W-1:0] in_addr,
    input  logic [4*3-1:0]      in_dump_num,
    input  logic [4*3-1:0]      in_init_num,
    input  logic [4*DATA_W-1:0] in_write_value,
    output logic                out_read,
    output logic                out_write,
    output logic                out_dump,
    output logic                out_init,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [2:0]          out_dump_num,
    output logic [2:0]          out_init_num,
    output logic [DATA_W-1:0]   out_write_value
);

    // 4:1 command select gated by grant_valid
    always_comb begin
        out_read        = 1'b0;
        out_write       = 1'b0;
        out_dump        = 1'b0;
        out_init        = 1'b0;
        out_addr        = {ADDR_W{1'b0}};
        out_dump_num    = 3'd0;
        out_init_num    = 3'd0;
        out_write_value = {DATA_W{1'b0}};
        if (grant_valid) begin
            out_read        = in_read[grant];
            out_write       = in_write[grant];
            out_dump        = in_dump[grant];
            out_init        = in_init[grant];
            out_addr        = in_addr[grant*ADDR_W +: ADDR_W];
            out_dump_num    = in_dump_num[grant*3 +: 3];
            out_init_num    = in_init_num[grant*3 +: 3];
            out_write_value = in_write_value[grant*DATA_W +: DATA_W];
        end else begin
            out_read = 1'b0;
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// AES-128 round sequencer: walks ARK/SUB/SHIFT/MIX through the rounds with a watchdog,
// and routes the currently granted step's SRAM requests to the shared controller.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES_NUM_ROUNDS,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [3:0]          round_num,
    output logic [3:0]          step_enable,
    input  logic [3:0]          step_finished,
    input  logic [3:0]          step_sramRead,
    input  logic [3:0]          step_sramWrite,
    input  logic [3:0]          step_sramDump,
    input  logic [3:0]          step_sramInit,
    input  logic [4*ADDR_W-1:0] step_sramAddr,
    input  logic [4*3-1:0]      step_sramDumpNum,
    input  logic [4*3-1:0]      step_sramInitNum,
    input  logic [4*DATA_W-1:0] step_sramWriteValue,
    output logic                sramRead,
    output logic                sramWrite,
    output logic                sramDump,
    output logic                sramInit,
    output logic [ADDR_W-1:0]   sramAddr,
    output logic [2:0]          sramDumpNum,
    output logic [2:0]          sramInitNum,
    output logic [DATA_W-1:0]   sramWriteValue
);

    localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      ROUND_LAST = 4'(NUM_ROUNDS);

    sched_state_e    state_q, state_d;
    step_e           step_q, step_d;
    logic [3:0]      round_q, round_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [3:0]      en_q, en_d;
    logic [3:0]      active_s;

    // Next-state, schedule and watchdog logic
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        round_d  = round_q;
        wd_d     = wd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        en_d     = en_q;
        active_s = step_onehot(step_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    step_d  = ARK;
                    round_d = 4'd0;
                    wd_d    = {WD_W{1'b0}};
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    en_d    = step_onehot(ARK);
                end else begin
                    busy_d = 1'b0;
                    en_d   = 4'b0000;
                end
            end
            RUN: begin
                // Only the active bit on its own advances; any stray bit is a protocol error
                if (step_finished == active_s) begin
                    state_d = GAP;
                    en_d    = 4'b0000;
                end else begin
                    if ((step_finished & ~active_s) != 4'b0000) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (wd_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        en_d    = 4'b0000;
                        busy_d  = 1'b0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = RUN;
                wd_d    = {WD_W{1'b0}};
                case (step_q)
                    ARK: begin
                        if (round_q < ROUND_LAST) begin
                            round_d = round_q + 4'd1;
                            step_d  = SUB;
                        end else begin
                            state_d = FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                    SUB:     step_d = SHIFT;
                    SHIFT:   step_d = (round_q < ROUND_LAST) ? MIX : ARK;
                    MIX:     step_d = ARK;
                    default: step_d = ARK;
                endcase
                if (state_d == RUN) begin
                    en_d = step_onehot(step_d);
                end else begin
                    en_d = 4'b0000;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                en_d    = 4'b0000;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                en_d    = 4'b0000;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= ARK;
            round_q <= 4'd0;
            wd_q    <= {WD_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign round_num   = round_q;
    assign step_enable = en_q;

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .grant           (step_q),
        .grant_valid     (state_q == RUN),
        .in_read         (step_sramRead),
        .in_write        (step_sramWrite),
        .in_dump         (step_sramDump),
        .in_init         (step_sramInit),
        .in_addr         (step_sramAddr),
        .in_dump_num     (step_sramDumpNum),
        .in_init_num     (step_sramInitNum),
        .in_write_value  (step_sramWriteValue),
        .out_read        (sramRead),
        .out_write       (sramWrite),
        .out_dump        (sramDump),
        .out_init        (sramInit),
        .out_addr        (sramAddr),
        .out_dump_num    (sramDumpNum),
        .out_init_num    (sramInitNum),
        .out_write_value (sramWriteValue)
    );

endmodule
